// File: rtl/edge_pkg.sv
// Shared parameters, state encoding and image layout
// for the edge-detector memory arbiter.
package edge_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;

  localparam int IMG_W        = 352;
  localparam int IMG_H        = 288;
  localparam int PIX_PER_WORD = 4;
  localparam int IMG_WORDS    = IMG_W * IMG_H / PIX_PER_WORD;
  localparam int RES_BASE     = IMG_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: rr names the requester
// that wins when both ask in the same cycle.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~rr | ~req[1]);
    gnt[1] = req[1] & (rr | ~req[0]);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with burst
// ownership, round-robin fallback and read-return routing.
module mem_arbiter #(
  parameter int ADDR_W    = edge_pkg::ADDR_W,
  parameter int DATA_W    = edge_pkg::DATA_W,
  parameter int MAX_BURST = edge_pkg::MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              hold0,
  input  logic              hold1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dataW0,
  input  logic [DATA_W-1:0] dataW1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] dataR0,
  output logic [DATA_W-1:0] dataR1,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataW,
  input  logic [DATA_W-1:0] dataR
);

  import edge_pkg::*;

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic              rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              pend_v_q, pend_v_d;
  logic              pend_idx_q, pend_idx_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dw_q;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              burst_ok;
  logic              keep0, keep1;

  arb_rr2 u_rr (
    .req ({req1, req0}),
    .rr  (rr_q),
    .gnt (rr_gnt)
  );

  assign burst_ok = cnt_q < CW'(MAX_BURST);
  assign cnt_inc  = burst_ok ? cnt_q + CW'(1) : cnt_q;

  // The owner only yields once its burst is spent
  // and the other side is actually waiting.
  assign keep0 = (state_q == OWN0) & req0
               & (burst_ok | ~req1);
  assign keep1 = (state_q == OWN1) & req1
               & (burst_ok | ~req0);

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      reset:           gnt = 2'b00;
      !reset && keep0: gnt = 2'b01;
      !reset && keep1: gnt = 2'b10;
      default:         gnt = rr_gnt;
    endcase
  end

  always_comb begin
    gnt0  = gnt[0];
    gnt1  = gnt[1];
    en    = |gnt;
    we    = (gnt[0] & we0) | (gnt[1] & we1);
    addr  = addr_q;
    dataW = dw_q;
    if (gnt[0]) begin
      addr  = addr0;
      dataW = dataW0;
    end else if (gnt[1]) begin
      addr  = addr1;
      dataW = dataW1;
    end
  end

  always_comb begin
    state_d    = IDLE;
    cnt_d      = '0;
    rr_d       = rr_q;
    pend_v_d   = en & ~we;
    pend_idx_d = gnt[1];
    if (gnt[0]) begin
      rr_d = 1'b1;
      if (hold0) begin
        state_d = OWN0;
        cnt_d   = (state_q == OWN0) ? cnt_inc : CW'(1);
      end
    end else if (gnt[1]) begin
      rr_d = 1'b0;
      if (hold1) begin
        state_d = OWN1;
        cnt_d   = (state_q == OWN1) ? cnt_inc : CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= 1'b0;
      addr_q     <= '0;
      dw_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      pend_idx_q <= pend_idx_d;
      addr_q     <= addr;
      dw_q       <= dataW;
    end
  end

  assign rvalid0 = pend_v_q & ~pend_idx_q;
  assign rvalid1 = pend_v_q & pend_idx_q;
  assign dataR0  = dataR;
  assign dataR1  = dataR;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against an
// ownership/round-robin reference model and a shadow memory.
module tb_mem_arbiter;

  import edge_pkg::*;

  logic              clk, reset;
  logic              req0, req1, hold0, hold1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1, addr;
  logic [DATA_W-1:0] dataW0, dataW1, dataW;
  logic [DATA_W-1:0] dataR, dataR0, dataR1;
  logic              gnt0, gnt1, rvalid0, rvalid1, en, we;

  logic [DATA_W-1:0] mem    [2**ADDR_W];
  logic [DATA_W-1:0] shadow [2**ADDR_W];

  int vectors = 0;
  int miscompares = 0;

  int                m_owner, m_cnt, m_rr, m_pidx;
  bit                m_pv;
  logic [DATA_W-1:0] m_pdata, m_last_dw, e_dw, e_rd;
  logic [ADDR_W-1:0] m_last_addr, e_addr;
  int                e_g;
  logic              e_we, e_rv0, e_rv1;
  logic [5:0]        e_ctl;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .hold0(hold0), .hold1(hold1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .dataW0(dataW0), .dataW1(dataW1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .dataR0(dataR0), .dataR1(dataR1),
    .en(en), .we(we), .addr(addr),
    .dataW(dataW), .dataR(dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= dataW;
      else dataR <= mem[addr];
    end

  function automatic logic [DATA_W-1:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void predict();
    logic [1:0] rq;
    rq = {req1, req0};
    e_g = -1;
    if (!reset) begin
      if (m_owner >= 0 && rq[m_owner] &&
          (m_cnt < MAX_BURST || !rq[1-m_owner]))
        e_g = m_owner;
      else if (rq == 2'b11) e_g = m_rr;
      else if (rq[0]) e_g = 0;
      else if (rq[1]) e_g = 1;
    end
    e_we   = (e_g == 0) ? we0 : (e_g == 1) ? we1 : 1'b0;
    e_addr = (e_g == 0) ? addr0 :
             (e_g == 1) ? addr1 : m_last_addr;
    e_dw   = (e_g == 0) ? dataW0 :
             (e_g == 1) ? dataW1 : m_last_dw;
    if (reset) begin
      e_addr = '0;
      e_dw   = '0;
    end
    e_rv0 = !reset && m_pv && m_pidx == 0;
    e_rv1 = !reset && m_pv && m_pidx == 1;
    e_rd  = m_pdata;
    e_ctl = {e_g == 0, e_g == 1, e_g >= 0,
             e_we, e_rv0, e_rv1};
  endfunction

  task automatic apply(
    input logic r, q0, q1, h0, h1, w0, w1,
    input logic [ADDR_W-1:0] a0, a1,
    input logic [DATA_W-1:0] d0, d1);
    @(negedge clk);
    reset = r;
    req0 = q0; req1 = q1;
    hold0 = h0; hold1 = h1;
    we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1;
    dataW0 = d0; dataW1 = d1;
    #1;
    predict();
  endtask

  task automatic commit();
    bit held;
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_rr = 0; m_pv = 0;
      m_last_addr = '0; m_last_dw = '0;
    end else begin
      m_pv = 0;
      if (e_g >= 0) begin
        m_last_addr = e_addr;
        m_last_dw   = e_dw;
        if (e_we) shadow[e_addr] = e_dw;
        else begin
          m_pv = 1; m_pidx = e_g;
          m_pdata = shadow[e_addr];
        end
        m_rr = 1 - e_g;
        held = (e_g == 0) ? hold0 : hold1;
        if (held) begin
          if (m_owner == e_g)
            m_cnt = (m_cnt < MAX_BURST) ? m_cnt + 1 : m_cnt;
          else
            m_cnt = 1;
          m_owner = e_g;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  task automatic pulse_reset();
    apply(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    commit();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            ADDR_W'($urandom), ADDR_W'($urandom),
            $urandom, $urandom);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL reset ctl got %b want %b",
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      vectors++;
      if ({addr, dataW} !== {e_addr, e_dw}) begin
        miscompares++;
        $display("FAIL reset bus got %h/%h want %h/%h",
          addr, dataW, e_addr, e_dw);
      end
      commit();
    end
  endtask

  task automatic test_single_read();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      apply(0, i == 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL single_read ctl got %b want %b",
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      if (i == 1) begin
        vectors++;
        if (rvalid0 !== 1'b1 || dataR0 !== init_word(0)) begin
          miscompares++;
          $display("FAIL single_read data got %b/%h want 1/%h",
            rvalid0, dataR0, init_word(0));
        end
      end
      commit();
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, i < 4, i < 4, 0, 0, 0, 0,
            ADDR_W'(i), ADDR_W'(100 + i), '0, '0);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL contention ctl got %b want %b",
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      if (i < 4) begin
        vectors++;
        if ({gnt1, gnt0} !== ((i % 2) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL contention order cyc %0d got %b%b",
            i, gnt1, gnt0);
        end
      end
      if (e_rv0 | e_rv1) begin
        vectors++;
        if ((e_rv0 ? dataR0 : dataR1) !== e_rd) begin
          miscompares++;
          $display("FAIL contention rdata got %h want %h",
            e_rv0 ? dataR0 : dataR1, e_rd);
        end
      end
      commit();
    end
  endtask

  task automatic test_burst();
    int run = 0;
    bit seen1 = 0;
    pulse_reset();
    for (int i = 0; i < 19; i++) begin
      apply(0, 1, 1, 1, 0, 0, 0,
            ADDR_W'($urandom_range(0, 63)),
            ADDR_W'($urandom_range(0, 63)), '0, '0);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL burst ctl cyc %0d got %b want %b", i,
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      if (e_rv0 | e_rv1) begin
        vectors++;
        if ((e_rv0 ? dataR0 : dataR1) !== e_rd) begin
          miscompares++;
          $display("FAIL burst rdata got %h want %h",
            e_rv0 ? dataR0 : dataR1, e_rd);
        end
      end
      if (gnt1) seen1 = 1;
      else if (!seen1 && gnt0) run++;
      commit();
    end
    vectors++;
    if (run !== MAX_BURST || !seen1) begin
      miscompares++;
      $display("FAIL burst length got %0d want %0d",
        run, MAX_BURST);
    end
  endtask

  task automatic test_write_read();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, i == 1, i == 0, 0, 0, 0, i == 0,
            ADDR_W'(RES_BASE), ADDR_W'(RES_BASE),
            '0, 32'hDEAD_BEEF);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL write_read ctl got %b want %b",
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      vectors++;
      if ({addr, dataW} !== {e_addr, e_dw}) begin
        miscompares++;
        $display("FAIL write_read bus got %h/%h want %h/%h",
          addr, dataW, e_addr, e_dw);
      end
      if (i == 2) begin
        vectors++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 ||
            dataR0 !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL write_read data got %b%b/%h want 10/%h",
            rvalid0, rvalid1, dataR0, 32'hDEAD_BEEF);
        end
      end
      commit();
    end
  endtask

  task automatic test_reset_mid_read();
    pulse_reset();
    apply(0, 1, 0, 0, 0, 0, 0, 16'd5, '0, '0, '0);
    vectors++;
    if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
      miscompares++;
      $display("FAIL mid_read grant got %b want %b",
        {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
    end
    #2 reset = 1'b1;
    commit();
    for (int i = 0; i < 2; i++) begin
      apply(i == 0, 1, 1, 0, 0, 0, 0, 16'd5, 16'd6, '0, '0);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL mid_read ctl got %b want %b",
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      if (i == 1) begin
        vectors++;
        if (gnt0 !== 1'b1 || rvalid0 !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_read after got g0=%b rv0=%b want 1/0",
            gnt0, rvalid0);
        end
      end
      commit();
    end
  endtask

  task automatic test_owner_release();
    bit h;
    h = 1'($urandom);
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      apply(0, i >= 3, i != 3, i == 3 && h, i < 3, 0, 0,
            ADDR_W'(20 + i), ADDR_W'(40 + i), '0, '0);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL release ctl cyc %0d got %b want %b", i,
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if (gnt0 !== (i == 3 ? 1'b1 : 1'(h))) begin
          miscompares++;
          $display("FAIL release gnt0 cyc %0d hold0=%b got %b",
            i, h, gnt0);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      apply($urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
            ADDR_W'($urandom_range(0, 7)),
            ADDR_W'($urandom_range(0, 7)),
            $urandom, $urandom);
      vectors++;
      if ({gnt0, gnt1, en, we, rvalid0, rvalid1} !== e_ctl) begin
        miscompares++;
        $display("FAIL random ctl cyc %0d got %b want %b", i,
          {gnt0, gnt1, en, we, rvalid0, rvalid1}, e_ctl);
      end
      vectors++;
      if ({addr, dataW} !== {e_addr, e_dw}) begin
        miscompares++;
        $display("FAIL random bus cyc %0d got %h/%h want %h/%h",
          i, addr, dataW, e_addr, e_dw);
      end
      if (e_rv0 | e_rv1) begin
        vectors++;
        if ((e_rv0 ? dataR0 : dataR1) !== e_rd) begin
          miscompares++;
          $display("FAIL random rdata cyc %0d got %h want %h",
            i, e_rv0 ? dataR0 : dataR1, e_rd);
        end
      end
      commit();
    end
  endtask

  initial begin
    reset = 1'b1;
    {req0, req1, hold0, hold1, we0, we1} = '0;
    addr0 = '0; addr1 = '0;
    dataW0 = '0; dataW1 = '0;
    dataR = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    m_owner = -1; m_cnt = 0; m_rr = 0; m_pv = 0;
    m_pidx = 0; m_pdata = '0;
    m_last_addr = '0; m_last_dw = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_burst();
    test_write_read();
    test_reset_mid_read();
    test_owner_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
